// File: rtl/mv_mdio_scheduler.sv
// MDIO transaction scheduler: arbitrates host requests and autonomous PHY status polls onto one MDIO master.
// The poller is compiled in only when MDIO_POLL_EN is defined.
//
// state     | meaning
// IDLE      | nothing in flight; pick the host slot first, else a pending poll
// ISSUE     | one-cycle read/write request pulse to the MDIO master
// WAIT_BUSY | waiting for the master to raise mdio_rw_busy
// WAIT_DONE | waiting for the master to drop mdio_rw_busy
// COMPLETE  | capture read data, signal completion
module mv_mdio_scheduler #(
   parameter logic [23:0] POLL_PERIOD = 24'd1250000,
   parameter logic [7:0]  POLL_REG    = 8'd1,
   parameter logic [3:0]  LINK_BIT    = 4'd2,
   parameter logic [15:0] TIMEOUT     = 16'd1023
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        host_rd_req,
   input  logic        host_wr_req,
   input  logic [7:0]  host_reg,
   input  logic [15:0] host_wr_data,
   output logic [15:0] host_rd_data,
   output logic        host_done,
   output logic        host_busy,
   output logic        host_err,
   output logic        mdio_rd_request,
   output logic        mdio_wr_request,
   output logic [7:0]  mdio_register,
   output logic [15:0] mdio_wr_data,
   input  logic        mdio_rw_busy,
   input  logic [15:0] mdio_rd_data,
   output logic        link_up,
   output logic [15:0] poll_data
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      COMPLETE  = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic        slot_valid, slot_wr;
   logic [7:0]  slot_reg;
   logic [15:0] slot_data;
   logic        cur_host, cur_wr;
   logic [15:0] tmo_cnt;
   logic        poll_pending;
   logic        host_done_q, host_err_q;
   logic        start_host, start_poll, tmo_load, tmo_hit, host_finish;
   logic        host_any, host_accept, host_drop;

   // host_done_q extends busy by one cycle so a pulse landing on the done cycle is still refused
   assign host_busy   = slot_valid | host_done_q;
   assign host_done   = host_done_q;
   assign host_err    = host_err_q;
   assign host_any    = host_rd_req | host_wr_req;
   assign host_accept = host_any & ~host_busy;
   assign host_drop   = (host_any & host_busy) | (host_rd_req & host_wr_req);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      start_host      = 1'b0;
      start_poll      = 1'b0;
      tmo_load        = 1'b0;
      tmo_hit         = 1'b0;
      mdio_rd_request = 1'b0;
      mdio_wr_request = 1'b0;
      case (state)
         IDLE: begin
            if (slot_valid) begin
               start_host = 1'b1;
               state_nxt  = ISSUE;
            end else if (poll_pending) begin
               start_poll = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE: begin
            mdio_wr_request = cur_wr;
            mdio_rd_request = ~cur_wr;
            tmo_load        = 1'b1;
            state_nxt       = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (mdio_rw_busy) begin
               tmo_load  = 1'b1;
               state_nxt = WAIT_DONE;
            end else if (tmo_cnt == 16'd0) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!mdio_rw_busy) begin
               state_nxt = COMPLETE;
            end else if (tmo_cnt == 16'd0) begin
               tmo_hit   = 1'b1;
               state_nxt = IDLE;
            end
         end
         COMPLETE: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      host_finish = cur_host & ((state == COMPLETE) | tmo_hit);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_valid    <= 1'b0;
         slot_wr       <= 1'b0;
         slot_reg      <= '0;
         slot_data     <= '0;
         cur_host      <= 1'b0;
         cur_wr        <= 1'b0;
         mdio_register <= '0;
         mdio_wr_data  <= '0;
         host_rd_data  <= '0;
         host_done_q   <= 1'b0;
         host_err_q    <= 1'b0;
         tmo_cnt       <= '0;
      end else begin
         if (host_accept) begin
            slot_valid <= 1'b1;
            slot_wr    <= host_wr_req;
            slot_reg   <= host_reg;
            slot_data  <= host_wr_data;
         end else if (host_finish) begin
            slot_valid <= 1'b0;
         end
         host_done_q <= host_finish;
         host_err_q  <= host_drop | (tmo_hit & cur_host);
         if (start_host) begin
            cur_host      <= 1'b1;
            cur_wr        <= slot_wr;
            mdio_register <= slot_reg;
            mdio_wr_data  <= slot_data;
         end else if (start_poll) begin
            cur_host      <= 1'b0;
            cur_wr        <= 1'b0;
            mdio_register <= POLL_REG;
            mdio_wr_data  <= '0;
         end
         if (host_finish && !cur_wr)
            host_rd_data <= tmo_hit ? 16'hFFFF : mdio_rd_data;
         // down-counter gives exactly TIMEOUT cycles in each wait phase
         if (tmo_load)
            tmo_cnt <= TIMEOUT - 16'd1;
         else if (tmo_cnt != 16'd0)
            tmo_cnt <= tmo_cnt - 16'd1;
      end
   end

`ifdef MDIO_POLL_EN
   logic [23:0] poll_cnt;
   logic        poll_wrap;

   assign poll_wrap = (poll_cnt == POLL_PERIOD - 24'd1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt     <= '0;
         poll_pending <= 1'b0;
         link_up      <= 1'b0;
         poll_data    <= '0;
      end else begin
         poll_cnt <= poll_wrap ? 24'd0 : poll_cnt + 24'd1;
         // a wrap on the same cycle as the clear re-arms the poll rather than losing it
         if (poll_wrap)
            poll_pending <= 1'b1;
         else if (state == ISSUE && !cur_host)
            poll_pending <= 1'b0;
         if (state == COMPLETE && !cur_host) begin
            poll_data <= mdio_rd_data;
            link_up   <= mdio_rd_data[LINK_BIT];
         end else if (tmo_hit && !cur_host) begin
            link_up <= 1'b0;
         end
      end
   end
`else
   logic unused_poll_cfg;

   assign poll_pending    = 1'b0;
   assign link_up         = 1'b0;
   assign poll_data       = 16'h0000;
   assign unused_poll_cfg = ^{POLL_PERIOD, LINK_BIT};
`endif

endmodule

// File: tb/tb_mv_mdio_scheduler.sv
// Scoreboard bench for mv_mdio_scheduler: stimulus queues expected MDIO requests and host completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mv_mdio_scheduler;

`ifdef MDIO_POLL_EN
   localparam bit POLL_ON = 1'b1;
`else
   localparam bit POLL_ON = 1'b0;
`endif

   logic        clock, reset_n;
   logic        host_rd_req, host_wr_req;
   logic [7:0]  host_reg;
   logic [15:0] host_wr_data, host_rd_data;
   logic        host_done, host_busy, host_err;
   logic        mdio_rd_request, mdio_wr_request;
   logic [7:0]  mdio_register;
   logic [15:0] mdio_wr_data;
   logic        mdio_rw_busy;
   logic [15:0] mdio_rd_data;
   logic        link_up;
   logic [15:0] poll_data;

   mv_mdio_scheduler #(
      .POLL_PERIOD(24'd16),
      .POLL_REG   (8'd1),
      .LINK_BIT   (4'd2),
      .TIMEOUT    (16'd8)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .host_rd_req    (host_rd_req),
      .host_wr_req    (host_wr_req),
      .host_reg       (host_reg),
      .host_wr_data   (host_wr_data),
      .host_rd_data   (host_rd_data),
      .host_done      (host_done),
      .host_busy      (host_busy),
      .host_err       (host_err),
      .mdio_rd_request(mdio_rd_request),
      .mdio_wr_request(mdio_wr_request),
      .mdio_register  (mdio_register),
      .mdio_wr_data   (mdio_wr_data),
      .mdio_rw_busy   (mdio_rw_busy),
      .mdio_rd_data   (mdio_rd_data),
      .link_up        (link_up),
      .poll_data      (poll_data)
   );

   typedef struct {
      bit          wr;
      logic [7:0]  rg;
      logic [15:0] data;
      int          at;
   } mdio_exp_t;

   typedef struct {
      logic [15:0] rd_data;
      bit          err;
      int          at;
   } done_exp_t;

   mdio_exp_t   mexp[$];
   done_exp_t   dexp[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          err_seen = 0;
   int          err_exp = 0;
   int          host_req_cnt = 0;
   int          last_host_cyc = -1;
   int          last_poll_cyc = -1;
   int          busy_len = 3;
   bit          no_busy = 1'b0;
   logic [15:0] resp_data = 16'h0000;
   logic [15:0] poll_resp = 16'h0004;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_m(input bit wr, input logic [7:0] rg, input logic [15:0] d, input int at);
      mdio_exp_t e;
      e.wr = wr; e.rg = rg; e.data = d; e.at = at;
      mexp.push_back(e);
   endtask

   task automatic push_d(input logic [15:0] rd, input bit err, input int at);
      done_exp_t e;
      e.rd_data = rd; e.err = err; e.at = at;
      dexp.push_back(e);
   endtask

   task automatic host_op(input bit rd, input bit wr, input logic [7:0] rg, input logic [15:0] d);
      host_rd_req  = rd;
      host_wr_req  = wr;
      host_reg     = rg;
      host_wr_data = d;
      @(negedge clock);
      host_rd_req  = 1'b0;
      host_wr_req  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((host_busy || mdio_rw_busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
   endtask

   // MDIO master model: busy rises one cycle after a request and stays up for busy_len cycles
   always begin
      @(negedge clock);
      if (mdio_rd_request || mdio_wr_request) begin
         mdio_rd_data = (mdio_rd_request && mdio_register == 8'd1) ? poll_resp : resp_data;
         if (!no_busy) begin
            @(negedge clock);
            mdio_rw_busy = 1'b1;
            repeat (busy_len) @(negedge clock);
            mdio_rw_busy = 1'b0;
         end
      end
   end

   always @(negedge clock) begin
      if (mdio_rd_request || mdio_wr_request) begin
         if (POLL_ON && mdio_rd_request && mdio_register == 8'd1) begin
            last_poll_cyc = cyc;
         end else begin
            host_req_cnt++;
            last_host_cyc = cyc;
            if (mexp.size() == 0) begin
               chk("unexpected_mdio_req", {24'd0, mdio_register}, 32'hFFFF_FFFF);
            end else begin
               mdio_exp_t e;
               e = mexp.pop_front();
               chk("req_both_pulses", {31'd0, mdio_rd_request & mdio_wr_request}, 32'd0);
               chk("req_kind_wr", {31'd0, mdio_wr_request}, {31'd0, e.wr});
               chk("req_register", {24'd0, mdio_register}, {24'd0, e.rg});
               if (e.wr) chk("req_wr_data", {16'd0, mdio_wr_data}, {16'd0, e.data});
               if (e.at >= 0) chk("req_latency_cycle", cyc, e.at);
            end
         end
      end
      if (host_done) begin
         if (dexp.size() == 0) begin
            chk("unexpected_host_done", 32'd1, 32'd0);
         end else begin
            done_exp_t d;
            d = dexp.pop_front();
            chk("done_rd_data", {16'd0, host_rd_data}, {16'd0, d.rd_data});
            chk("done_err", {31'd0, host_err}, {31'd0, d.err});
            if (d.at >= 0) chk("done_cycle", cyc, d.at);
         end
      end
      if (host_err) err_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_expired actual=%0d required=finished", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_host_busy"},    {31'd0, host_busy},       32'd0);
      chk({tag, "_host_done"},    {31'd0, host_done},       32'd0);
      chk({tag, "_host_err"},     {31'd0, host_err},        32'd0);
      chk({tag, "_mdio_rd_req"},  {31'd0, mdio_rd_request}, 32'd0);
      chk({tag, "_mdio_wr_req"},  {31'd0, mdio_wr_request}, 32'd0);
      chk({tag, "_mdio_reg"},     {24'd0, mdio_register},   32'd0);
      chk({tag, "_mdio_wr_data"}, {16'd0, mdio_wr_data},    32'd0);
      chk({tag, "_host_rd_data"}, {16'd0, host_rd_data},    32'd0);
      chk({tag, "_link_up"},      {31'd0, link_up},         32'd0);
      chk({tag, "_poll_data"},    {16'd0, poll_data},       32'd0);
   endtask

   initial begin
      int n, c0, base, cnt0;
      reset_n      = 1'b0;
      host_rd_req  = 1'b0;
      host_wr_req  = 1'b0;
      host_reg     = 8'h00;
      host_wr_data = 16'h0000;
      mdio_rw_busy = 1'b0;
      mdio_rd_data = 16'h0000;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      c0 = cyc;

      // host read lands on the same cycle as the first poll-counter wrap
      resp_data = 16'h0BEE;
      while (cyc < c0 + 15) @(negedge clock);
      push_m(1'b0, 8'h02, 16'h0000, -1);
      push_d(16'h0BEE, 1'b0, -1);
      host_op(1'b1, 1'b0, 8'h02, 16'h0000);
      wait_idle("poll_race");
      repeat (20) @(negedge clock);
`ifdef MDIO_POLL_EN
      chk("poll_after_host", {31'd0, last_poll_cyc > last_host_cyc}, 32'd1);
      chk("poll_link_up", {31'd0, link_up}, 32'd1);
      chk("poll_data", {16'd0, poll_data}, 32'h0004);
`else
      chk("nopoll_link_up", {31'd0, link_up}, 32'd0);
      chk("nopoll_poll_data", {16'd0, poll_data}, 32'd0);
`endif

      // plain host read, busy for 3 cycles
      resp_data = 16'h0141;
      base = cyc;
      push_m(1'b0, 8'h02, 16'h0000, POLL_ON ? -1 : base + 2);
      push_d(16'h0141, 1'b0, POLL_ON ? -1 : base + 8);
      host_op(1'b1, 1'b0, 8'h02, 16'h0000);
      chk("busy_after_pulse", {31'd0, host_busy}, 32'd1);
      wait_idle("host_read");

      // host write leaves host_rd_data alone
      base = cyc;
      push_m(1'b1, 8'h00, 16'h8000, POLL_ON ? -1 : base + 2);
      push_d(16'h0141, 1'b0, -1);
      host_op(1'b0, 1'b1, 8'h00, 16'h8000);
      wait_idle("host_write");

      // second pulse while busy is dropped, slot keeps the first request
      resp_data = 16'h2222;
      push_m(1'b0, 8'h03, 16'h0000, -1);
      push_d(16'h2222, 1'b0, -1);
      err_exp++;
      host_op(1'b1, 1'b0, 8'h03, 16'h0000);
      host_op(1'b0, 1'b1, 8'h05, 16'hDEAD);
      chk("drop_busy_err", {31'd0, host_err}, 32'd1);
      wait_idle("drop_busy");

      // read and write together: write wins, read dropped
      push_m(1'b1, 8'h06, 16'h1234, -1);
      push_d(16'h2222, 1'b0, -1);
      err_exp++;
      host_op(1'b1, 1'b1, 8'h06, 16'h1234);
      chk("rdwr_err", {31'd0, host_err}, 32'd1);
      chk("rdwr_busy", {31'd0, host_busy}, 32'd1);
      wait_idle("rdwr");

      // master never goes busy: timeout after 8 cycles in WAIT_BUSY
      no_busy = 1'b1;
      base = cyc;
      push_m(1'b0, 8'h07, 16'h0000, POLL_ON ? -1 : base + 2);
      push_d(16'hFFFF, 1'b1, POLL_ON ? -1 : base + 11);
      err_exp++;
      host_op(1'b1, 1'b0, 8'h07, 16'h0000);
      wait_idle("timeout");
      repeat (2) @(negedge clock);
      no_busy = 1'b0;

      // reset in WAIT_DONE abandons the read without host_done
      busy_len  = 20;
      resp_data = 16'h3333;
      cnt0 = host_req_cnt;
      push_m(1'b0, 8'h08, 16'h0000, -1);
      host_op(1'b1, 1'b0, 8'h08, 16'h0000);
      n = 0;
      while (host_req_cnt == cnt0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("reset_req_seen", {31'd0, host_req_cnt != cnt0}, 32'd1);
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (30) @(negedge clock);
      busy_len = 3;
`ifndef MDIO_POLL_EN
      chk("final_link_up", {31'd0, link_up}, 32'd0);
`endif

      chk("mdio_queue_empty", mexp.size(), 32'd0);
      chk("done_queue_empty", dexp.size(), 32'd0);
      chk("host_err_count", err_seen, err_exp);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
